// File: rtl/alu_if.sv
// Handshake bus for alu_secuencial: request side (op + operands) and result side (value + flags).
interface alu_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       codigoOP;
    logic [WIDTH-1:0] operandoA;
    logic [WIDTH-1:0] operandoB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] resultado;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             err;

    modport master (
        output in_valid, codigoOP, operandoA, operandoB, out_ready,
        input  in_ready, out_valid, resultado, N, Z, C, V, err
    );

    modport slave (
        input  in_valid, codigoOP, operandoA, operandoB, out_ready,
        output in_ready, out_valid, resultado, N, Z, C, V, err
    );
endinterface

// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready handshake; mul/div/mod iterate one bit per cycle.
// Define ALU_SAT_EN to make add/sub saturate to signed limits on overflow.
module alu_secuencial #(
    parameter int unsigned WIDTH = 8
) (
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH) + 1;
    localparam int unsigned CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef ALU_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [4:0] OpAdd = 5'b00000;
    localparam logic [4:0] OpSub = 5'b00001;
    localparam logic [4:0] OpMul = 5'b00010;
    localparam logic [4:0] OpAnd = 5'b00101;
    localparam logic [4:0] OpOr  = 5'b00110;
    localparam logic [4:0] OpXor = 5'b01000;
    localparam logic [4:0] OpDiv = 5'b01010;
    localparam logic [4:0] OpMod = 5'b01011;
    localparam logic [4:0] OpShl = 5'b01100;
    localparam logic [4:0] OpShr = 5'b01101;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or remainder in the low WIDTH+1 bits
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   b_q, b_d;          // multiplier (shifted) or divisor (held)
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

    // Single-cycle datapath, fed straight from the bus at accept.
    logic [WIDTH-1:0] a, b, oc_res;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum, shl_t, shr_t;
    logic             oc_c, oc_v, oc_err;

    always_comb begin
        a      = bus.operandoA;
        b      = bus.operandoB;
        amt    = b[SHW-1:0];
        oc_res = '0;
        oc_c   = 1'b0;
        oc_v   = 1'b0;
        oc_err = 1'b0;
        sum    = '0;
        shl_t  = '0;
        shr_t  = '0;
        case (bus.codigoOP)
            OpAdd: begin
                sum    = {1'b0, a} + {1'b0, b};
                oc_res = sum[WIDTH-1:0];
                oc_c   = sum[WIDTH];
                oc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (oc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                oc_res = a - b;
                oc_c   = (a >= b);
                oc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (oc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd: oc_res = a & b;
            OpOr:  oc_res = a | b;
            OpXor: oc_res = a ^ b;
            OpShl: begin
                if (amt < SHW'(WIDTH)) begin
                    shl_t  = {1'b0, a} << amt;
                    oc_res = shl_t[WIDTH-1:0];
                    oc_c   = shl_t[WIDTH];
                end
            end
            OpShr: begin
                if (amt < SHW'(WIDTH)) begin
                    shr_t  = {a, 1'b0} >> amt;
                    oc_res = shr_t[WIDTH:1];
                    oc_c   = shr_t[0];
                end
            end
            OpMul, OpDiv, OpMod: oc_err = 1'b0;
            default: oc_err = 1'b1;
        endcase
        // Only add/sub can raise oc_v; the sign of A tells which limit was crossed.
        if (SatEn && oc_v) begin
            oc_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // One iteration of shift-add multiply and restoring divide.
    logic [2*WIDTH-1:0] it_acc, it_mcand;
    logic [WIDTH-1:0]   it_b, it_quo;
    logic [WIDTH:0]     shifted, trial;

    always_comb begin
        it_acc   = acc_q;
        it_mcand = mcand_q;
        it_b     = b_q;
        it_quo   = quo_q;
        shifted  = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, b_q};
        if (op_q == OpMul) begin
            it_acc   = acc_q + (b_q[0] ? mcand_q : '0);
            it_mcand = mcand_q << 1;
            it_b     = b_q >> 1;
        end else if (!trial[WIDTH]) begin
            it_acc = {{(WIDTH-1){1'b0}}, trial};
            it_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            it_acc = {{(WIDTH-1){1'b0}}, shifted};
            it_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    logic             load;
    logic             new_ill;
    logic [WIDTH-1:0] new_res;
    logic             new_c, new_v, new_err;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        b_d     = b_q;
        quo_d   = quo_q;
        load    = 1'b0;
        new_ill = 1'b0;
        new_res = '0;
        new_c   = 1'b0;
        new_v   = 1'b0;
        new_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d  = bus.codigoOP;
                    cnt_d = '0;
                    acc_d = '0;
                    if (bus.codigoOP inside {OpMul, OpDiv, OpMod}) begin
                        mcand_d = {{WIDTH{1'b0}}, bus.operandoA};
                        quo_d   = bus.operandoA;
                        b_d     = bus.operandoB;
                        state_d = StBusy;
                    end else begin
                        load    = 1'b1;
                        new_res = oc_res;
                        new_c   = oc_c;
                        new_v   = oc_v;
                        new_err = oc_err;
                        new_ill = oc_err;
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                acc_d   = it_acc;
                mcand_d = it_mcand;
                b_d     = it_b;
                quo_d   = it_quo;
                cnt_d   = cnt_q + 1'b1;
                // The last iteration and the result capture share one edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    load    = 1'b1;
                    state_d = StDone;
                    if (op_q == OpMul) begin
                        new_res = it_acc[WIDTH-1:0];
                        new_v   = |it_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        new_res = (op_q == OpDiv) ? it_quo : it_acc[WIDTH-1:0];
                        new_v   = (b_q == '0);
                        new_err = (b_q == '0);
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        res_d = load ? new_res : res_q;
        n_d   = load ? new_res[WIDTH-1] && !new_ill : n_q;
        z_d   = load ? (new_res == '0) && !new_ill : z_q;
        c_d   = load ? new_c : c_q;
        v_d   = load ? new_v : v_q;
        err_d = load ? new_err : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.resultado = res_q;
    assign bus.N         = n_q;
    assign bus.Z         = z_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// Directed-vector bench for alu_secuencial (WIDTH=8); expectations follow ALU_SAT_EN if defined.
module tb_alu_secuencial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_if #(.WIDTH(8)) bus_if ();

    alu_secuencial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] fl;   // {N,Z,C,V,err}
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus_if.N, bus_if.Z, bus_if.C, bus_if.V, bus_if.err};
    endfunction

    task automatic do_op(input string tag, input vec_t v);
        int lat;
        bus_if.in_valid  = 1'b1;
        bus_if.codigoOP  = v.op;
        bus_if.operandoA = v.a;
        bus_if.operandoB = v.b;
        @(posedge clk);
        #1;
        bus_if.in_valid  = 1'b0;
        bus_if.operandoA = ~v.a;   // must be ignored after accept
        bus_if.operandoB = ~v.b;
        check_eq({tag, " in_ready"}, 32'(bus_if.in_ready), 32'd0);
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, " lat"}, lat, v.lat);
        check_eq({tag, " res"}, 32'(bus_if.resultado), 32'(v.res));
        check_eq({tag, " flags"}, 32'(flags()), 32'(v.fl));
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.codigoOP  = 5'd0;
        bus_if.operandoA = 8'd0;
        bus_if.operandoB = 8'd0;

`ifdef ALU_SAT_EN
        vecs.push_back('{5'b00000, 8'h7F, 8'h01, 8'h7F, 5'b00010, 1});
        vecs.push_back('{5'b00000, 8'h80, 8'h80, 8'h80, 5'b10110, 1});
`else
        vecs.push_back('{5'b00000, 8'h7F, 8'h01, 8'h80, 5'b10010, 1});
        vecs.push_back('{5'b00000, 8'h80, 8'h80, 8'h00, 5'b01110, 1});
`endif
        vecs.push_back('{5'b00000, 8'hFF, 8'h01, 8'h00, 5'b01100, 1});
        vecs.push_back('{5'b00001, 8'h05, 8'h07, 8'hFE, 5'b10000, 1});
        vecs.push_back('{5'b00001, 8'h07, 8'h07, 8'h00, 5'b01100, 1});
        vecs.push_back('{5'b00010, 8'h10, 8'h10, 8'h00, 5'b01010, 9});
        vecs.push_back('{5'b00010, 8'h0C, 8'h0A, 8'h78, 5'b00000, 9});
        vecs.push_back('{5'b01010, 8'd200, 8'd7, 8'd28, 5'b00000, 9});
        vecs.push_back('{5'b01011, 8'd200, 8'd7, 8'd4, 5'b00000, 9});
        vecs.push_back('{5'b01010, 8'h33, 8'h00, 8'hFF, 5'b10011, 9});
        vecs.push_back('{5'b01011, 8'h33, 8'h00, 8'h33, 5'b00011, 9});
        vecs.push_back('{5'b01100, 8'h81, 8'h01, 8'h02, 5'b00100, 1});
        vecs.push_back('{5'b01100, 8'h81, 8'h00, 8'h81, 5'b10000, 1});
        vecs.push_back('{5'b01101, 8'h81, 8'h08, 8'h00, 5'b01000, 1});
        vecs.push_back('{5'b01101, 8'h81, 8'h01, 8'h40, 5'b00100, 1});
        vecs.push_back('{5'b11111, 8'h12, 8'h34, 8'h00, 5'b00001, 1});
        vecs.push_back('{5'b00101, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1});
        vecs.push_back('{5'b00110, 8'hF0, 8'h3C, 8'hFC, 5'b10000, 1});
        vecs.push_back('{5'b01000, 8'hF0, 8'h3C, 8'hCC, 5'b10000, 1});

        #12;
        check_eq("rst in_ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("rst out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("rst res", 32'(bus_if.resultado), 32'd0);
        check_eq("rst flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held while out_ready=0; a second request is dropped.
        bus_if.in_valid  = 1'b1;
        bus_if.codigoOP  = 5'b00000;
        bus_if.operandoA = 8'h12;
        bus_if.operandoB = 8'h34;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_if.in_valid = (k == 1 || k == 2);
            bus_if.codigoOP = 5'b00001;
            check_eq($sformatf("bp res%0d", k), 32'(bus_if.resultado), 32'h46);
            check_eq($sformatf("bp flags%0d", k), 32'(flags()), 32'd0);
            check_eq($sformatf("bp in_ready%0d", k), 32'(bus_if.in_ready), 32'd0);
            check_eq($sformatf("bp out_valid%0d", k), 32'(bus_if.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check_eq("bp ack in_ready", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check_eq("bp not queued", 32'(bus_if.out_valid), 32'd0);

        // Reset in the middle of a multiply.
        bus_if.in_valid  = 1'b1;
        bus_if.codigoOP  = 5'b00010;
        bus_if.operandoA = 8'h0C;
        bus_if.operandoB = 8'h0A;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mrst in_ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("mrst out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("mrst res", 32'(bus_if.resultado), 32'd0);
        check_eq("mrst flags", 32'(flags()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("mrst discarded", 32'(bus_if.out_valid), 32'd0);
        do_op("post rst add", '{5'b00000, 8'h03, 8'h04, 8'h07, 5'b00000, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
